// File: rtl/rx_iq_intf.sv
// Receive-side I/Q interface: channel select, saturating digital gain,
// FWFT sample FIFO toward the rx core, loopback tap and overflow statistics.
module rx_iq_intf #(
   parameter int WIFI_IQ_PACK_DATA_WIDTH = 64,
   parameter int IQ_DATA_WIDTH           = 16,
   parameter int C_M00_AXIS_TDATA_WIDTH  = 64,
   parameter int FIFO_ADDR_WIDTH         = 9
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [WIFI_IQ_PACK_DATA_WIDTH-1:0] wifi_iq_pack,
   input  logic                               wifi_iq_valid,
   input  logic                               ch_sel,
   input  logic [9:0]                         rx_gain,
   input  logic                               flush,
   output logic [IQ_DATA_WIDTH-1:0]           rf_i,
   output logic [IQ_DATA_WIDTH-1:0]           rf_q,
   output logic                               rf_iq_valid,
   input  logic                               rf_iq_ready,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]  data_loopback,
   output logic                               data_loopback_valid,
   output logic [FIFO_ADDR_WIDTH:0]           fifo_level,
   output logic                               rx_almost_full,
   output logic                               ovf_sticky,
   output logic [15:0]                        ovf_count,
   input  logic                               ovf_clr
);

   localparam int unsigned DEPTH    = 1 << FIFO_ADDR_WIDTH;
   localparam int unsigned AF_LEVEL = (DEPTH * 3) / 4;
   localparam int          CW       = WIFI_IQ_PACK_DATA_WIDTH / 2;
   localparam int          PW       = IQ_DATA_WIDTH + 10;
   localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (IQ_DATA_WIDTH - 1)) - 1);
   localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

   function automatic logic [IQ_DATA_WIDTH-1:0] gain_sat(
      input logic signed [IQ_DATA_WIDTH-1:0] x,
      input logic signed [9:0]               g
   );
      logic signed [PW-1:0] prod;
      logic signed [PW-1:0] sh;
      prod = PW'(x) * PW'(g);
      sh   = prod >>> 7;
      if (sh > SAT_MAX)
         return {1'b0, {(IQ_DATA_WIDTH-1){1'b1}}};
      else if (sh < SAT_MIN)
         return {1'b1, {(IQ_DATA_WIDTH-1){1'b0}}};
      else
         return sh[IQ_DATA_WIDTH-1:0];
   endfunction

   logic                     ch_sel_q;
   logic                     clear;
   logic                     s1_valid;
   logic [CW-1:0]            s1_data;
   logic                     s2_valid;
   logic [IQ_DATA_WIDTH-1:0] s2_i;
   logic [IQ_DATA_WIDTH-1:0] s2_q;

   // A channel switch is treated exactly like an explicit flush.
   assign clear = flush | (ch_sel ^ ch_sel_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_sel_q <= ch_sel;
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s2_valid <= 1'b0;
         s2_i     <= '0;
         s2_q     <= '0;
      end else begin
         ch_sel_q <= ch_sel;
         s1_valid <= wifi_iq_valid & ~clear;
         s1_data  <= ch_sel ? wifi_iq_pack[2*CW-1:CW] : wifi_iq_pack[CW-1:0];
         s2_valid <= s1_valid & ~clear;
         s2_i     <= gain_sat($signed(s1_data[IQ_DATA_WIDTH-1:0]), $signed(rx_gain));
         s2_q     <= gain_sat($signed(s1_data[2*IQ_DATA_WIDTH-1:IQ_DATA_WIDTH]), $signed(rx_gain));
      end
   end

   assign data_loopback       = C_M00_AXIS_TDATA_WIDTH'({s2_q, s2_i});
   assign data_loopback_valid = s2_valid;

   logic [2*IQ_DATA_WIDTH-1:0] mem [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
   logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
   logic [FIFO_ADDR_WIDTH:0]   count;
   logic                       empty;
   logic                       full;
   logic                       pop;
   logic                       push;
   logic                       drop;
   logic [2*IQ_DATA_WIDTH-1:0] head;

   assign empty = (count == '0);
   assign full  = (count == (FIFO_ADDR_WIDTH+1)'(DEPTH));
   assign pop   = ~empty & rf_iq_ready;
   // A pop frees the slot in the same edge, so a full FIFO still accepts.
   assign push  = s2_valid & (~full | pop) & ~clear;
   assign drop  = s2_valid & full & ~pop & ~clear;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {s2_q, s2_i};
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + (FIFO_ADDR_WIDTH+1)'(push) - (FIFO_ADDR_WIDTH+1)'(pop);
      end
   end

   assign head           = mem[rd_ptr];
   assign rf_iq_valid    = ~empty;
   assign rf_i           = empty ? '0 : head[IQ_DATA_WIDTH-1:0];
   assign rf_q           = empty ? '0 : head[2*IQ_DATA_WIDTH-1:IQ_DATA_WIDTH];
   assign fifo_level     = count;
   assign rx_almost_full = (count >= (FIFO_ADDR_WIDTH+1)'(AF_LEVEL));

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end else if (ovf_clr) begin
         ovf_sticky <= drop;
         ovf_count  <= {15'd0, drop};
      end else if (drop) begin
         ovf_sticky <= 1'b1;
         if (ovf_count != '1)
            ovf_count <= ovf_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_rx_iq_intf.sv
// Directed and randomized bench for rx_iq_intf against a queue-based
// behavioural model checked after every clock edge.
module tb_rx_iq_intf;

   localparam int DEPTH = 512;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] wifi_iq_pack;
   logic        wifi_iq_valid;
   logic        ch_sel;
   logic [9:0]  rx_gain;
   logic        flush;
   logic [15:0] rf_i;
   logic [15:0] rf_q;
   logic        rf_iq_valid;
   logic        rf_iq_ready;
   logic [63:0] data_loopback;
   logic        data_loopback_valid;
   logic [9:0]  fifo_level;
   logic        rx_almost_full;
   logic        ovf_sticky;
   logic [15:0] ovf_count;
   logic        ovf_clr;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   rx_iq_intf #(
      .WIFI_IQ_PACK_DATA_WIDTH(64),
      .IQ_DATA_WIDTH(16),
      .C_M00_AXIS_TDATA_WIDTH(64),
      .FIFO_ADDR_WIDTH(9)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wifi_iq_pack(wifi_iq_pack),
      .wifi_iq_valid(wifi_iq_valid),
      .ch_sel(ch_sel),
      .rx_gain(rx_gain),
      .flush(flush),
      .rf_i(rf_i),
      .rf_q(rf_q),
      .rf_iq_valid(rf_iq_valid),
      .rf_iq_ready(rf_iq_ready),
      .data_loopback(data_loopback),
      .data_loopback_valid(data_loopback_valid),
      .fifo_level(fifo_level),
      .rx_almost_full(rx_almost_full),
      .ovf_sticky(ovf_sticky),
      .ovf_count(ovf_count),
      .ovf_clr(ovf_clr)
   );

   // Reference model: two in-flight slots, the FIFO as a queue of {Q,I}.
   logic        m_s1_v;
   logic [31:0] m_s1_d;
   logic        m_s2_v;
   logic [15:0] m_s2_i;
   logic [15:0] m_s2_q;
   logic [31:0] m_q[$];
   logic        m_sticky;
   logic [15:0] m_cnt;
   logic        m_chq;

   function automatic logic [15:0] scale(input logic [15:0] x, input logic [9:0] g);
      int p;
      p = int'($signed(x)) * int'($signed(g));
      p = p >>> 7;
      if (p > 32767)
         p = 32767;
      else if (p < -32768)
         p = -32768;
      return p[15:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      logic        clr_now;
      logic        pop;
      logic        drop;
      logic [31:0] sel;
      sel = ch_sel ? wifi_iq_pack[63:32] : wifi_iq_pack[31:0];
      if (rst) begin
         m_s1_v = 1'b0; m_s1_d = '0; m_s2_v = 1'b0; m_s2_i = '0; m_s2_q = '0;
         m_q.delete(); m_sticky = 1'b0; m_cnt = '0; m_chq = ch_sel;
      end else begin
         clr_now = flush || (ch_sel != m_chq);
         pop     = (m_q.size() != 0) && rf_iq_ready;
         drop    = !clr_now && m_s2_v && (m_q.size() == DEPTH) && !pop;
         if (ovf_clr) begin
            m_sticky = drop;
            m_cnt    = drop ? 16'd1 : 16'd0;
         end else if (drop) begin
            m_sticky = 1'b1;
            if (m_cnt != 16'hFFFF)
               m_cnt++;
         end
         if (clr_now)
            m_q.delete();
         else begin
            if (pop)
               void'(m_q.pop_front());
            if (m_s2_v && !drop)
               m_q.push_back({m_s2_q, m_s2_i});
         end
         m_s2_v = m_s1_v && !clr_now;
         m_s2_i = scale(m_s1_d[15:0], rx_gain);
         m_s2_q = scale(m_s1_d[31:16], rx_gain);
         m_s1_v = wifi_iq_valid && !clr_now;
         m_s1_d = sel;
         m_chq  = ch_sel;
      end
   endtask

   task automatic check_all();
      logic [31:0] h;
      h = (m_q.size() != 0) ? m_q[0] : 32'd0;
      chk("rf_iq_valid", 64'(rf_iq_valid), 64'(m_q.size() != 0));
      chk("rf_i", 64'(rf_i), 64'(h[15:0]));
      chk("rf_q", 64'(rf_q), 64'(h[31:16]));
      chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
      chk("rx_almost_full", 64'(rx_almost_full), 64'(m_q.size() >= 384));
      chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
      chk("ovf_count", 64'(ovf_count), 64'(m_cnt));
      chk("lb_valid", 64'(data_loopback_valid), 64'(m_s2_v));
      chk("lb_data", data_loopback, {32'd0, m_s2_q, m_s2_i});
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      rst = 1'b1; wifi_iq_pack = '0; wifi_iq_valid = 1'b0; ch_sel = 1'b0;
      rx_gain = 10'd128; flush = 1'b0; rf_iq_ready = 1'b0; ovf_clr = 1'b0;
      m_q.delete();
      tick(); tick();
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_valid", 64'(rf_iq_valid), 64'd0);
      rst = 1'b0;

      // unity gain, ch0, three-cycle latency to FIFO head
      wifi_iq_pack = 64'h0000_0000_1234_0567; wifi_iq_valid = 1'b1; rf_iq_ready = 1'b1;
      tick();
      wifi_iq_valid = 1'b0;
      tick();
      chk("lat_early", 64'(rf_iq_valid), 64'd0);
      tick();
      chk("lat_valid", 64'(rf_iq_valid), 64'd1);
      chk("lat_i", 64'(rf_i), 64'h0567);
      chk("lat_q", 64'(rf_q), 64'h1234);
      tick();
      chk("lat_gone", 64'(rf_iq_valid), 64'd0);

      // ch1, gain x2
      ch_sel = 1'b1; rx_gain = 10'd256;
      tick();
      wifi_iq_pack = 64'h0100_FF00_0000_0000; wifi_iq_valid = 1'b1;
      tick();
      wifi_iq_valid = 1'b0;
      tick(); tick();
      chk("g2_i", 64'(rf_i), 64'hFE00);
      chk("g2_q", 64'(rf_q), 64'h0200);
      tick();

      // saturation at max gain, then most-negative gain
      rx_gain = 10'd511;
      wifi_iq_pack = {16'hC000, 16'h4000, 32'h0}; wifi_iq_valid = 1'b1;
      tick();
      wifi_iq_pack = {16'h0000, 16'h0080, 32'h0};
      tick();
      wifi_iq_valid = 1'b0; rx_gain = 10'h200;
      tick();
      chk("sat_i", 64'(rf_i), 64'h7FFF);
      chk("sat_q", 64'(rf_q), 64'h8000);
      tick();
      chk("neg_i", 64'(rf_i), 64'hFE00);
      tick();

      // overflow: 520 samples into a stalled FIFO
      rf_iq_ready = 1'b0; rx_gain = 10'd128; ch_sel = 1'b0;
      tick();
      for (int i = 0; i < 520; i++) begin
         wifi_iq_pack = {$urandom, $urandom}; wifi_iq_valid = 1'b1;
         tick();
      end
      wifi_iq_valid = 1'b0;
      tick(); tick(); tick();
      chk("ovf_level", 64'(fifo_level), 64'd512);
      chk("ovf_af", 64'(rx_almost_full), 64'd1);
      chk("ovf_sticky_set", 64'(ovf_sticky), 64'd1);
      chk("ovf_count8", 64'(ovf_count), 64'd8);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("clr_sticky", 64'(ovf_sticky), 64'd0);
      chk("clr_count", 64'(ovf_count), 64'd0);

      // full FIFO with concurrent write and pop: no drops
      wifi_iq_valid = 1'b1;
      tick(); tick();
      rf_iq_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wifi_iq_pack = {$urandom, $urandom};
         tick();
      end
      wifi_iq_valid = 1'b0;
      tick(); tick();
      chk("wp_level", 64'(fifo_level), 64'd512);
      chk("wp_count", 64'(ovf_count), 64'd0);
      for (int i = 0; i < 515; i++)
         tick();
      chk("drain_level", 64'(fifo_level), 64'd0);

      // channel switch clears buffered samples, stats untouched
      rf_iq_ready = 1'b0;
      for (int i = 0; i < 100; i++) begin
         wifi_iq_pack = {$urandom, $urandom}; wifi_iq_valid = 1'b1;
         tick();
      end
      wifi_iq_valid = 1'b0;
      tick(); tick();
      chk("buf_level", 64'(fifo_level), 64'd100);
      ch_sel = ~ch_sel;
      tick();
      chk("sw_valid", 64'(rf_iq_valid), 64'd0);
      chk("sw_level", 64'(fifo_level), 64'd0);
      chk("sw_count", 64'(ovf_count), 64'd0);

      // ovf_clr coinciding with a drop
      wifi_iq_valid = 1'b1;
      for (int i = 0; i < 515; i++) begin
         wifi_iq_pack = {$urandom, $urandom};
         tick();
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("clrdrop_count", 64'(ovf_count), 64'd1);
      chk("clrdrop_sticky", 64'(ovf_sticky), 64'd1);

      // randomized traffic
      for (int i = 0; i < 900; i++) begin
         wifi_iq_pack  = {$urandom, $urandom};
         wifi_iq_valid = ($urandom_range(0, 3) != 0);
         rf_iq_ready   = ($urandom_range(0, 2) == 0);
         flush         = ($urandom_range(0, 63) == 0);
         ovf_clr       = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 15) == 0)
            rx_gain = 10'($urandom);
         if ($urandom_range(0, 127) == 0)
            ch_sel = ~ch_sel;
         tick();
      end
      flush = 1'b0; ovf_clr = 1'b0;

      // reset mid-stream
      wifi_iq_valid = 1'b1; rf_iq_ready = 1'b0;
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      tick();
      chk("mrst_valid", 64'(rf_iq_valid), 64'd0);
      chk("mrst_level", 64'(fifo_level), 64'd0);
      chk("mrst_i", 64'(rf_i), 64'd0);
      chk("mrst_lb", data_loopback, 64'd0);
      chk("mrst_lbv", 64'(data_loopback_valid), 64'd0);
      chk("mrst_ovf", 64'(ovf_count), 64'd0);
      rst = 1'b0; wifi_iq_valid = 1'b0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
